// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment scan driver.
//   - seg_bit_e : segment bit order within a 7-bit pattern (bit0 = a ... bit6 = g)
//   - SEG_*     : active-low segment patterns for digits 0-9, hex A-F, dash, blank
package seg7_pkg;

  typedef enum int unsigned {
    SEG_A = 0,
    SEG_B = 1,
    SEG_C = 2,
    SEG_D = 3,
    SEG_E = 4,
    SEG_F = 5,
    SEG_G = 6
  } seg_bit_e;

  localparam int unsigned SEG_W = int'(SEG_G) + 1;

  // Active-low patterns, written g..a (MSB first)
  localparam logic [SEG_W-1:0] SEG_DIGIT_0 = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_DIGIT_1 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_DIGIT_2 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_DIGIT_3 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_DIGIT_4 = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_DIGIT_5 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_DIGIT_6 = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_DIGIT_7 = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_DIGIT_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_DIGIT_9 = 7'b0011000;
  localparam logic [SEG_W-1:0] SEG_HEX_A   = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_HEX_B   = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_HEX_C   = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_HEX_D   = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_HEX_E   = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_HEX_F   = 7'b0001110;
  localparam logic [SEG_W-1:0] SEG_DASH    = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_BLANK   = 7'b1111111;

endpackage

// File: rtl/seg7_glyph.sv
// seg7_glyph: combinational nibble -> active-low 7-segment pattern.
//   i_nibble   : 4-bit digit value
//   i_hex_mode : 1 = show A-F for 10-15, 0 = show dash for 10-15
//   o_seg      : active-low segments, bit6 = g ... bit0 = a
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0]       i_nibble,
  input  logic             i_hex_mode,
  output logic [SEG_W-1:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    unique case (i_nibble)
      4'h0: o_seg = SEG_DIGIT_0;
      4'h1: o_seg = SEG_DIGIT_1;
      4'h2: o_seg = SEG_DIGIT_2;
      4'h3: o_seg = SEG_DIGIT_3;
      4'h4: o_seg = SEG_DIGIT_4;
      4'h5: o_seg = SEG_DIGIT_5;
      4'h6: o_seg = SEG_DIGIT_6;
      4'h7: o_seg = SEG_DIGIT_7;
      4'h8: o_seg = SEG_DIGIT_8;
      4'h9: o_seg = SEG_DIGIT_9;
      4'hA: o_seg = i_hex_mode ? SEG_HEX_A : SEG_DASH;
      4'hB: o_seg = i_hex_mode ? SEG_HEX_B : SEG_DASH;
      4'hC: o_seg = i_hex_mode ? SEG_HEX_C : SEG_DASH;
      4'hD: o_seg = i_hex_mode ? SEG_HEX_D : SEG_DASH;
      4'hE: o_seg = i_hex_mode ? SEG_HEX_E : SEG_DASH;
      4'hF: o_seg = i_hex_mode ? SEG_HEX_F : SEG_DASH;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for NUM_DIGITS common-anode
// 7-segment digits with double-buffered (tear-free) value loading.
//   clk_in, rst_in    : clock, synchronous active-high reset
//   load_in           : capture value_in/dp_in/blank_in into the shadow set
//   value_in          : nibble i = digit i (digit 0 rightmost)
//   dp_in, blank_in   : per-digit decimal point / forced blank
//   hex_mode_in       : live glyph mode (1 = hex, 0 = BCD with dash for 10-15)
//   seg_out, dp_out   : active-low segments / decimal point (registered)
//   an_out            : active-low digit enables, all off in first cycle of a slot
//   frame_done_out    : one-cycle pulse after the last slot of each frame
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          LZ_SUPPRESS = 1'b1
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    load_in,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    hex_mode_in,
  output logic [SEG_W-1:0]        seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done_out
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;

  logic [4*NUM_DIGITS-1:0] r_sh_val;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic [NUM_DIGITS-1:0]   r_sh_blank;
  logic                    r_pending;

  logic [4*NUM_DIGITS-1:0] r_act_val;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [NUM_DIGITS-1:0]   r_act_blank;

  logic                    w_cnt_last;
  logic                    w_frame_end;
  logic [3:0]              w_nib;
  logic                    w_dp;
  logic                    w_blank;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic                    w_zero_run;
  logic [NUM_DIGITS-1:0]   w_an_next;
  logic [SEG_W-1:0]        w_glyph;

  assign w_cnt_last  = (r_cnt == CW'(REFRESH_DIV - 1));
  assign w_frame_end = w_cnt_last && (r_idx == IW'(NUM_DIGITS - 1));

  // Scan position
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_cnt_last) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Shadow/active double buffer. On a frame-end edge the active set takes the
  // shadow contents as they were before this edge, so a simultaneous load only
  // lands in the shadow and stays pending for the next frame end.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_sh_val    <= '0;
      r_sh_dp     <= '0;
      r_sh_blank  <= '0;
      r_pending   <= 1'b0;
      r_act_val   <= '0;
      r_act_dp    <= '0;
      r_act_blank <= '0;
    end else begin
      if (w_frame_end && r_pending) begin
        r_act_val   <= r_sh_val;
        r_act_dp    <= r_sh_dp;
        r_act_blank <= r_sh_blank;
      end
      if (load_in) begin
        r_sh_val   <= value_in;
        r_sh_dp    <= dp_in;
        r_sh_blank <= blank_in;
        r_pending  <= 1'b1;
      end else if (w_frame_end) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Current digit selection and anode pattern
  always_comb begin
    w_nib     = '0;
    w_dp      = 1'b0;
    w_blank   = 1'b0;
    w_an_next = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib   = r_act_val[4*i +: 4];
        w_dp    = r_act_dp[i];
        w_blank = r_act_blank[i] | w_lz[i];
        if (r_cnt != '0) begin
          w_an_next[i] = 1'b0;
        end
      end
    end
  end

  // Leading-zero blanking: walk from the most significant digit down while
  // nibbles and dp bits stay zero; digit 0 is always shown.
  always_comb begin
    w_lz       = '0;
    w_zero_run = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      w_zero_run = w_zero_run
                 & (r_act_val[4*(NUM_DIGITS-1-k) +: 4] == 4'h0)
                 & ~r_act_dp[NUM_DIGITS-1-k];
      if (NUM_DIGITS - 1 - k != 0) begin
        w_lz[NUM_DIGITS-1-k] = LZ_SUPPRESS & w_zero_run;
      end
    end
  end

  seg7_glyph u_glyph (
    .i_nibble   (w_nib),
    .i_hex_mode (hex_mode_in),
    .o_seg      (w_glyph)
  );

  // Registered outputs, one cycle behind the scan state
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      seg_out        <= SEG_BLANK;
      dp_out         <= 1'b1;
      an_out         <= '1;
      frame_done_out <= 1'b0;
    end else begin
      seg_out        <= w_blank ? SEG_BLANK : w_glyph;
      dp_out         <= w_blank ? 1'b1 : ~w_dp;
      an_out         <= w_an_next;
      frame_done_out <= w_frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int N = 4;
  localparam int D = 4;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          load_in = 1'b0;
  logic [4*N-1:0] value_in = '0;
  logic [N-1:0]  dp_in = '0;
  logic [N-1:0]  blank_in = '0;
  logic          hex_mode_in = 1'b0;
  logic [6:0]    seg_out;
  logic          dp_out;
  logic [N-1:0]  an_out;
  logic          frame_done_out;

  always #5 clk_in = ~clk_in;

  seg7_scan_driver #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (D),
    .LZ_SUPPRESS (1'b1)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .load_in        (load_in),
    .value_in       (value_in),
    .dp_in          (dp_in),
    .blank_in       (blank_in),
    .hex_mode_in    (hex_mode_in),
    .seg_out        (seg_out),
    .dp_out         (dp_out),
    .an_out         (an_out),
    .frame_done_out (frame_done_out)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Glyph table straight from the digit/hex pattern list (index = nibble)
  logic [6:0] hexg [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Model state: cycle count since reset plus shadow/active sets
  int          m_t = 0;
  bit          m_valid = 1'b0;
  bit          m_pend = 1'b0;
  logic [15:0] m_sh_v = '0, m_act_v = '0;
  logic [3:0]  m_sh_dp = '0, m_sh_bl = '0, m_act_dp = '0, m_act_bl = '0;

  function automatic bit model_blank(int d);
    if (m_act_bl[d]) return 1'b1;
    return (d > 0) && ((m_act_v >> (4*d)) == 0) && ((m_act_dp >> d) == 0);
  endfunction

  function automatic logic [6:0] model_seg(int d, bit hex);
    int nib;
    nib = int'((m_act_v >> (4*d)) & 16'hF);
    if (model_blank(d)) return 7'b1111111;
    if (!hex && nib > 9) return 7'b0111111;
    return hexg[nib];
  endfunction

  always @(posedge clk_in) begin
    bit         r, ld, hx, fe, chk;
    logic [6:0] es;
    logic       edp, efd;
    logic [3:0] ean;
    int         c, d;
    r  = rst_in;
    ld = load_in;
    hx = hex_mode_in;
    if (r) begin
      es = 7'h7F; edp = 1'b1; ean = 4'hF; efd = 1'b0;
      m_t = 0; m_pend = 0; m_valid = 1;
      m_sh_v = '0; m_sh_dp = '0; m_sh_bl = '0;
      m_act_v = '0; m_act_dp = '0; m_act_bl = '0;
      chk = 1'b1;
    end else begin
      chk = m_valid;
      c   = m_t % D;
      d   = (m_t / D) % N;
      ean = (c == 0) ? 4'hF : ~(4'b0001 << d);
      es  = model_seg(d, hx);
      edp = model_blank(d) ? 1'b1 : ~m_act_dp[d];
      fe  = (m_t % (N*D)) == (N*D - 1);
      efd = fe;
      if (fe && m_pend) begin
        m_act_v = m_sh_v; m_act_dp = m_sh_dp; m_act_bl = m_sh_bl;
      end
      if (ld) begin
        m_sh_v = value_in; m_sh_dp = dp_in; m_sh_bl = blank_in; m_pend = 1;
      end else if (fe) begin
        m_pend = 0;
      end
      m_t++;
    end
    #1;
    if (chk) begin
      check("model_seg", seg_out, es);
      check("model_dp", dp_out, edp);
      check("model_an", an_out, ean);
      check("model_fd", frame_done_out, efd);
    end
  end

  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_in);
      if (frame_done_out === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("frame_done_seen", seen, 1);
  endtask

  task automatic wait_slot(input string nm, input logic [3:0] an,
                           input logic [6:0] seg, input logic dp);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_in);
      if (an_out === an) begin
        found = 1'b1;
        break;
      end
    end
    check({nm, "_found"}, found, 1);
    check({nm, "_seg"}, seg_out, seg);
    check({nm, "_dp"}, dp_out, dp);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    value_in = v; dp_in = dp; blank_in = bl; load_in = 1'b1;
    @(negedge clk_in);
    load_in = 1'b0;
  endtask

  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;

  initial begin
    int cyc;
    // Reset held for three cycles
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      check("rst_seg", seg_out, BLANK);
      check("rst_an", an_out, 4'hF);
      check("rst_dp", dp_out, 1);
      check("rst_fd", frame_done_out, 0);
    end
    rst_in = 1'b0;
    wait_slot("post_rst_d0", 4'b1110, 7'b1000000, 1'b1);
    wait_slot("post_rst_d1", 4'b1101, BLANK, 1'b1);

    // BCD 1234
    wait_frame();
    do_load(16'h1234, 4'b0000, 4'b0000);
    wait_frame();
    wait_slot("v1234_d0", 4'b1110, 7'b0011001, 1'b1);
    wait_slot("v1234_d1", 4'b1101, 7'b0110000, 1'b1);
    wait_slot("v1234_d2", 4'b1011, 7'b0100100, 1'b1);
    wait_slot("v1234_d3", 4'b0111, 7'b1111001, 1'b1);

    // Leading zeros, then a dp that stops suppression at digit 2
    wait_frame();
    do_load(16'h0070, 4'b0000, 4'b0000);
    wait_frame();
    wait_slot("v0070_d0", 4'b1110, 7'b1000000, 1'b1);
    wait_slot("v0070_d1", 4'b1101, 7'b1111000, 1'b1);
    wait_slot("v0070_d2", 4'b1011, BLANK, 1'b1);
    wait_slot("v0070_d3", 4'b0111, BLANK, 1'b1);
    wait_frame();
    do_load(16'h0070, 4'b0100, 4'b0000);
    wait_frame();
    wait_slot("v0070dp_d2", 4'b1011, 7'b1000000, 1'b0);
    wait_slot("v0070dp_d3", 4'b0111, BLANK, 1'b1);

    // Forced blank on digit 1
    wait_frame();
    do_load(16'h1234, 4'b0000, 4'b0010);
    wait_frame();
    wait_slot("blank_d1", 4'b1101, BLANK, 1'b1);

    // Hex vs BCD glyphs for ABCF
    hex_mode_in = 1'b1;
    wait_frame();
    do_load(16'hABCF, 4'b0000, 4'b0000);
    wait_frame();
    wait_slot("hex_d0", 4'b1110, 7'b0001110, 1'b1);
    wait_slot("hex_d3", 4'b0111, 7'b0001000, 1'b1);
    hex_mode_in = 1'b0;
    wait_frame();
    wait_slot("bcd_d0", 4'b1110, DASH, 1'b1);
    wait_slot("bcd_d1", 4'b1101, DASH, 1'b1);
    wait_slot("bcd_d2", 4'b1011, DASH, 1'b1);
    wait_slot("bcd_d3", 4'b0111, DASH, 1'b1);

    // Load mid-frame at idx 2: rest of frame keeps old glyphs
    wait_frame();
    wait_slot("mid_d2_pre", 4'b1011, DASH, 1'b1);
    do_load(16'h1111, 4'b0000, 4'b0000);
    check("mid_d2_post", seg_out, DASH);
    wait_slot("mid_d3_old", 4'b0111, DASH, 1'b1);
    wait_slot("mid_d0_new", 4'b1110, 7'b1111001, 1'b1);
    wait_frame();
    cyc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_in);
      cyc++;
      if (frame_done_out === 1'b1) break;
    end
    check("frame_period", cyc, 16);

    // Reset at idx 2 with a pending load
    wait_frame();
    do_load(16'h5555, 4'b0000, 4'b0000);
    wait_slot("prerst_d2", 4'b1011, 7'b1111001, 1'b1);
    rst_in = 1'b1;
    @(negedge clk_in);
    check("midrst_seg", seg_out, BLANK);
    check("midrst_an", an_out, 4'hF);
    check("midrst_dp", dp_out, 1);
    check("midrst_fd", frame_done_out, 0);
    rst_in = 1'b0;
    wait_slot("after_rst_d0", 4'b1110, 7'b1000000, 1'b1);
    wait_slot("after_rst_d1", 4'b1101, BLANK, 1'b1);
    wait_frame();
    wait_frame();
    wait_slot("after_rst2_d0", 4'b1110, 7'b1000000, 1'b1);
    repeat (4) @(negedge clk_in);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clock cycles per digit slot (legal >= 2).
REQ-003 SHALL have parameter LZ_SUPPRESS, default 1, enables leading-zero blanking.
REQ-004 SHALL have port clk_in, input, 1, sole clock; all logic rising-edge.
REQ-005 SHALL have port rst_in, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port load_in, input, 1, capture strobe for value_in/dp_in/blank_in.
REQ-007 SHALL have port value_in, input, 4*NUM_DIGITS, nibble i = digit i; digit 0 least significant and rightmost.
REQ-008 SHALL have ports dp_in and blank_in, input, NUM_DIGITS each, per-digit decimal point and forced blank.
REQ-009 SHALL have port hex_mode_in, input, 1, 1 = hex glyphs, 0 = BCD glyphs; sampled live, not latched.
REQ-010 SHALL have port seg_out, output, 7, active-low segments, bit6 = g ... bit0 = a.
REQ-011 SHALL have port dp_out, output, 1, active-low decimal point.
REQ-012 SHALL have port an_out, output, NUM_DIGITS, active-low digit enables.
REQ-013 SHALL have port frame_done_out, output, 1, one-cycle pulse per completed scan frame.

Function
REQ-014 Prescaler cnt counts 0..REFRESH_DIV-1 and wraps; at cnt = REFRESH_DIV-1, digit index idx advances, NUM_DIGITS-1 wraps to 0.
REQ-015 Frame end = edge where cnt = REFRESH_DIV-1 and idx = NUM_DIGITS-1; frame_done_out SHALL be high exactly the following cycle.
REQ-016 load_in high SHALL copy value_in/dp_in/blank_in into shadow registers and set pending; a later load before frame end overwrites shadow (newest wins).
REQ-017 At frame end with pending set, shadow SHALL transfer to active registers and pending clear; display never changes mid-frame (no tearing).
REQ-018 load_in on the frame-end edge SHALL write shadow and leave pending set; the active set receives the previous shadow contents if pending was already set, otherwise is unchanged; the new value displays after the next frame end.
REQ-019 seg_out, dp_out, an_out SHALL be registers loaded every clock from current idx, cnt, active set, hex_mode_in (one-cycle lag behind scan state).
REQ-020 Ghost gap: when cnt = 0, an_out SHALL be all ones; otherwise an_out[idx] = 0, all other bits 1.
REQ-021 Glyphs 0-9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0011000.
REQ-022 Hex mode nibbles A-F: 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
REQ-023 BCD mode nibbles 10-15 SHALL show dash 0111111.
REQ-024 dp_out SHALL equal inverted active dp of idx.
REQ-025 Blanked digit (active blank bit set, or LZ suppressed): seg_out = 1111111 and dp_out = 1; anode still driven per REQ-020.
REQ-026 LZ suppression (LZ_SUPPRESS = 1): digit i > 0 blanked when nibble i and all more-significant nibbles are zero and their dp bits are 0; digit 0 never suppressed.

Reset
REQ-027 While rst_in high: cnt = 0, idx = 0, shadow/active/pending = 0, seg_out = 1111111, dp_out = 1, an_out all ones, frame_done_out = 0.
REQ-028 Reset mid-frame SHALL take effect on the next edge and discard any pending load.

Structure
REQ-029 Shared package seg7_pkg SHALL hold the segment-pattern constants (digits, A-F, dash, blank) and segment bit-order definition.
REQ-030 Glyph lookup SHALL be one combinational sub-module seg7_glyph (nibble, hex_mode -> 7-bit pattern); scan, latch and LZ logic stay in seg7_scan_driver.

Verification (NUM_DIGITS = 4, REFRESH_DIV = 4)
REQ-031 Hold rst_in 3 cycles, release -> seg_out 1111111, an_out 1111, dp_out 1 during reset and first post-reset cycle; then digit 0 shows 1000000, digits 1-3 blank.
REQ-032 Load 0x1234, hex_mode 0 -> after frame end: slot an_out 1110 seg 0011001; 1101 seg 0110000; 1011 seg 0100100; 0111 seg 1111001; an_out 1111 first cycle of each slot.
REQ-033 Load 0x0070, LZ_SUPPRESS 1 -> digits 3, 2 seg 1111111; digit 1 1111000; digit 0 1000000; with dp_in = 0100 digit 2 shows 1000000 and dp_out 0.
REQ-034 Load 0xABCF: hex_mode 1 -> digit 0 0001110, digit 3 0001000; hex_mode 0 -> all four 0111111.
REQ-035 Load 0x1111 while idx = 2 -> digits 2, 3 keep old glyphs this frame; new glyphs from next digit 0; frame_done_out pulses once per 16 cycles.
REQ-036 Assert rst_in at idx = 2 with pending load -> outputs reset next cycle; after release display shows 0, pending value never appears.
